// File: rtl/count_seq_checker_if.sv
// Monitor bus between the counter under test (master) and the sequence checker (slave).
interface count_seq_checker_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
) ();
    logic [WIDTH-1:0]  count_in;
    logic              count_valid;
    logic              up_clear;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [1:0]        state;

    modport master (
        output count_in, count_valid, up_clear,
        input  locked, err_pulse, err_sticky, wrap_pulse, wrap_count, state
    );

    modport slave (
        input  count_in, count_valid, up_clear,
        output locked, err_pulse, err_sticky, wrap_pulse, wrap_count, state
    );
endinterface

// File: rtl/count_seq_checker.sv
// Checks that a counter stream follows the modulo-2^WIDTH increment sequence,
// locks onto it, and reports sequence errors and wrap-arounds.
module count_seq_checker #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic                clock,
    input  logic                clear,
    count_seq_checker_if.slave  bus
);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0]  MAX_VAL  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    // LOCKED encoded as 2'b10 so that bit 1 is the locked flag directly
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            st;
    logic [WIDTH-1:0]  prev;
    logic [GOOD_W-1:0] good_cnt;
    logic              err_pulse;
    logic              err_sticky;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [WIDTH-1:0]  exp_val;
    logic              good;

    assign exp_val = prev + WIDTH'(1);
    assign good    = (bus.count_in == exp_val);

    always_ff @(posedge clock) begin
        if (clear) begin
            st         <= HUNT;
            prev       <= '0;
            good_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (bus.up_clear) begin
                // upstream restart: expect the stream to resume from 0
                st       <= SYNC;
                prev     <= '0;
                good_cnt <= '0;
            end else if (bus.count_valid) begin
                prev <= bus.count_in;
                case (st)
                    HUNT: begin
                        good_cnt <= '0;
                        st       <= SYNC;
                    end
                    SYNC: begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            good_cnt <= '0;
                            st       <= LOCKED;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            if (prev == MAX_VAL) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_count != WRAP_MAX) begin
                                    wrap_count <= wrap_count + WRAP_W'(1);
                                end
                            end
                        end else begin
                            err_pulse  <= 1'b1;
                            err_sticky <= 1'b1;
                            good_cnt   <= '0;
                            st         <= SYNC;
                        end
                    end
                    default: begin
                        good_cnt <= '0;
                        st       <= HUNT;
                    end
                endcase
            end
        end
    end

    assign bus.state      = st;
    assign bus.locked     = st[1];
    assign bus.err_pulse  = err_pulse;
    assign bus.err_sticky = err_sticky;
    assign bus.wrap_pulse = wrap_pulse;
    assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios then random traffic against a behavioural model.
module tb_count_seq_checker;
    localparam int unsigned WIDTH    = 3;
    localparam int unsigned LOCK_CNT = 2;
    localparam int unsigned WRAP_W   = 2;
    localparam int MOD  = 1 << WIDTH;
    localparam int WMAX = (1 << WRAP_W) - 1;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    count_seq_checker_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

    count_seq_checker #(
        .WIDTH(WIDTH),
        .LOCK_CNT(LOCK_CNT),
        .WRAP_W(WRAP_W)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 hunting, 1 syncing, 2 locked
    int m_mode   = 0;
    int m_prev   = 0;
    int m_streak = 0;
    int m_wraps  = 0;
    int m_sticky = 0;
    int m_errp   = 0;
    int m_wrapp  = 0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_update(input bit c, input bit u, input bit v, input int cin);
        bit in_order;
        m_errp  = 0;
        m_wrapp = 0;
        if (c) begin
            m_mode = 0; m_prev = 0; m_streak = 0; m_wraps = 0; m_sticky = 0;
        end else if (u) begin
            m_mode = 1; m_prev = 0; m_streak = 0;
        end else if (v) begin
            in_order = (cin == (m_prev + 1) % MOD);
            if (m_mode == 0) begin
                m_mode = 1;
                m_streak = 0;
            end else if (m_mode == 1) begin
                m_streak = in_order ? m_streak + 1 : 0;
                if (m_streak == LOCK_CNT) begin
                    m_mode = 2;
                    m_streak = 0;
                end
            end else if (in_order) begin
                if (m_prev == MOD - 1) begin
                    m_wrapp = 1;
                    if (m_wraps < WMAX) m_wraps++;
                end
            end else begin
                m_errp = 1; m_sticky = 1; m_mode = 1; m_streak = 0;
            end
            m_prev = cin;
        end
    endtask

    task automatic step(input bit c, input bit u, input bit v, input int cin);
        clear           = c;
        bus.up_clear    = u;
        bus.count_valid = v;
        bus.count_in    = WIDTH'(cin);
        @(posedge clock);
        model_update(c, u, v, cin);
        #1;
        check("state",      int'(bus.state),      m_mode);
        check("locked",     int'(bus.locked),     (m_mode == 2) ? 1 : 0);
        check("err_pulse",  int'(bus.err_pulse),  m_errp);
        check("err_sticky", int'(bus.err_sticky), m_sticky);
        check("wrap_pulse", int'(bus.wrap_pulse), m_wrapp);
        check("wrap_count", int'(bus.wrap_count), m_wraps);
    endtask

    task automatic sample(input int cin);
        step(1'b0, 1'b0, 1'b1, cin);
    endtask

    initial begin
        int nxt;
        // reset with junk on the other inputs
        step(1'b1, 1'b1, 1'b1, int'($urandom_range(0, MOD - 1)));
        step(1'b1, 1'b0, 1'b1, int'($urandom_range(0, MOD - 1)));
        check("rst_state",  int'(bus.state), 0);
        check("rst_wcount", int'(bus.wrap_count), 0);

        // lock on 5,6,7
        sample(5);
        check("lock_sync", int'(bus.state), 1);
        sample(6);
        check("lock_early", int'(bus.locked), 0);
        sample(7);
        check("lock_locked", int'(bus.locked), 1);
        check("lock_nowrap", int'(bus.wrap_pulse), 0);

        // wrap 7 -> 0
        sample(0);
        check("wrap_pulse", int'(bus.wrap_pulse), 1);
        check("wrap_count", int'(bus.wrap_count), 1);
        sample(1);
        check("wrap_single", int'(bus.wrap_pulse), 0);

        // stall while locked
        sample(2);
        sample(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, MOD - 1)));
        sample(4);
        check("stall_locked", int'(bus.locked), 1);
        check("stall_noerr", int'(bus.err_sticky), 0);

        // skip error: 4 -> 7, then relock on 0,1
        sample(7);
        check("err_pulse", int'(bus.err_pulse), 1);
        check("err_state", int'(bus.state), 1);
        sample(0);
        check("err_once", int'(bus.err_pulse), 0);
        sample(1);
        check("relock", int'(bus.locked), 1);
        check("sticky_held", int'(bus.err_sticky), 1);

        // upstream clear, then 0,1,2
        step(1'b0, 1'b1, 1'b1, 5);
        check("upclr_state", int'(bus.state), 1);
        check("upclr_noerr", int'(bus.err_pulse), 0);
        sample(0);
        sample(1);
        check("upclr_notyet", int'(bus.locked), 0);
        sample(2);
        check("upclr_locked", int'(bus.locked), 1);

        // many wraps: wrap_count must saturate at 3
        nxt = 3;
        for (int i = 0; i < 40; i++) begin
            sample(nxt);
            nxt = (nxt + 1) % MOD;
        end
        check("wrap_sat", int'(bus.wrap_count), 3);

        // clear mid-sequence
        step(1'b1, 1'b1, 1'b1, 3);
        check("midclr_state", int'(bus.state), 0);
        check("midclr_sticky", int'(bus.err_sticky), 0);
        check("midclr_wcount", int'(bus.wrap_count), 0);

        // random traffic, mostly in-order samples
        for (int i = 0; i < 3000; i++) begin
            bit c, u, v;
            int cin;
            c   = ($urandom_range(0, 199) == 0);
            u   = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) != 0);
            cin = ($urandom_range(0, 9) < 8) ? (m_prev + 1) % MOD
                                              : int'($urandom_range(0, MOD - 1));
            step(c, u, v, cin);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
